// File: rtl/gas_level_serial_tx.sv
// ============================================================================
// Module   : gas_level_serial_tx
// Purpose  : Frames a gas-level code as start, MSB-first data, even parity,
//            stop bits on a single-wire line toward the gas detector receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gas_level_serial_tx #(
  parameter int DATA_W     = 3,
  parameter int BIT_CYCLES = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [DATA_W-1:0] lvl_in,
  input  logic              lvl_valid,
  output logic              lvl_ready,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BMAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_PEN   = CW'((BIT_CYCLES > 1) ? BIT_CYCLES - 2 : 0);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] STOP_PEN  = BW'((STOP_BITS > 1) ? STOP_BITS - 2 : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;

  assign lvl_ready = (state == IDLE);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (lvl_valid) begin
            state   <= START;
            shreg   <= lvl_in;
            par     <= ^lvl_in;
            dout    <= 1'b1;
            busy    <= 1'b1;
            cyc_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            dout    <= shreg[DATA_W-1];
            shreg   <= shreg << 1;
            state   <= DATA;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              dout    <= par;
              state   <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              dout    <= shreg[DATA_W-1];
              shreg   <= shreg << 1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        PARITY: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            dout    <= 1'b0;
            state   <= STOP;
            done    <= (BIT_CYCLES == 1) && (STOP_BITS == 1);
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        STOP: begin
          // done is registered, so it is raised one cycle ahead of the last stop cycle
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              done    <= (BIT_CYCLES == 1) && (bit_cnt == STOP_PEN);
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
            done    <= (cyc_cnt == CYC_PEN) && (bit_cnt == STOP_LAST);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          dout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gas_level_serial_tx.sv
// Bench for gas_level_serial_tx: three parameter sets driven with directed and
// random frames, checked against a frame-list model built from the line rules.
`default_nettype none

module tb_gas_level_serial_tx;

  localparam int NI = 3;
  localparam int BCS [NI] = '{1, 4, 2};
  localparam int SBS [NI] = '{1, 1, 3};

  logic               clk;
  logic               arst;
  logic [NI-1:0][2:0] lvl_in;
  logic [NI-1:0]      lvl_valid;
  logic [NI-1:0]      lvl_ready;
  logic [NI-1:0]      dout;
  logic [NI-1:0]      busy;
  logic [NI-1:0]      done;

  int checks   = 0;
  int failures = 0;

  gas_level_serial_tx #(.DATA_W(3), .BIT_CYCLES(1), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .arst(arst), .lvl_in(lvl_in[0]), .lvl_valid(lvl_valid[0]),
    .lvl_ready(lvl_ready[0]), .dout(dout[0]), .busy(busy[0]), .done(done[0]));

  gas_level_serial_tx #(.DATA_W(3), .BIT_CYCLES(4), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .arst(arst), .lvl_in(lvl_in[1]), .lvl_valid(lvl_valid[1]),
    .lvl_ready(lvl_ready[1]), .dout(dout[1]), .busy(busy[1]), .done(done[1]));

  gas_level_serial_tx #(.DATA_W(3), .BIT_CYCLES(2), .STOP_BITS(3)) u_dut2 (
    .clk(clk), .arst(arst), .lvl_in(lvl_in[2]), .lvl_valid(lvl_valid[2]),
    .lvl_ready(lvl_ready[2]), .dout(dout[2]), .busy(busy[2]), .done(done[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Idle-line check on instance k for n cycles, sampled 1 time unit after each edge.
  task automatic check_idle(input int k, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({dout[k], busy[k], done[k], lvl_ready[k]} !== 4'b0001) begin
        failures++;
        $display("FAIL %s k=%0d cyc=%0d got dout/busy/done/ready=%b want 0001",
                 name, k, i, {dout[k], busy[k], done[k], lvl_ready[k]});
      end
      @(posedge clk); #1;
    end
  endtask

  // Present a code; returns one unit after the accepting edge.
  task automatic present(input int k, input logic [2:0] code, input string name);
    checks++;
    if (lvl_ready[k] !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready k=%0d got=%b want=1", name, k, lvl_ready[k]);
    end
    lvl_in[k]    = code;
    lvl_valid[k] = 1'b1;
    @(posedge clk); #1;
  endtask

  // Check a whole frame just after its accept edge against the expanded bit list.
  task automatic run_frame(input int k, input logic [2:0] code, input bit noise,
                           input bit keep_valid, input string name);
    logic bits[$];
    logic exp_line[$];
    int   f;
    bits.push_back(1'b1);
    for (int b = 2; b >= 0; b--) bits.push_back(code[b]);
    bits.push_back(code[0] ^ code[1] ^ code[2]);
    for (int s = 0; s < SBS[k]; s++) bits.push_back(1'b0);
    foreach (bits[j]) for (int c = 0; c < BCS[k]; c++) exp_line.push_back(bits[j]);
    f = exp_line.size();
    if (!keep_valid) lvl_valid[k] = 1'b0;
    for (int i = 0; i < f; i++) begin
      checks++;
      if ({dout[k], busy[k], done[k], lvl_ready[k]} !== {exp_line[i], 1'b1, (i == f - 1), 1'b0}) begin
        failures++;
        $display("FAIL %s k=%0d code=%b cyc=%0d got dout/busy/done/ready=%b want %b",
                 name, k, code, i, {dout[k], busy[k], done[k], lvl_ready[k]},
                 {exp_line[i], 1'b1, (i == f - 1), 1'b0});
      end
      if (noise) begin
        lvl_in[k]    = 3'($urandom);
        lvl_valid[k] = (i == f - 1) ? 1'b0 : 1'($urandom);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    arst      = 1'b0;
    lvl_valid = '1;
    for (int i = 0; i < 6; i++) begin
      lvl_in = 9'($urandom);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ({dout[k], busy[k], done[k], lvl_ready[k]} !== 4'b0001) begin
          failures++;
          $display("FAIL reset_hold k=%0d got=%b want=0001", k, {dout[k], busy[k], done[k], lvl_ready[k]});
        end
      end
      @(posedge clk); #1;
    end
    lvl_valid = '0;
    #2 arst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) check_idle(k, 2, "post_reset_idle");
  endtask

  task automatic test_basic();
    logic [5:0] pat;
    pat = 6'b110100;
    present(0, 3'b101, "basic");
    lvl_valid[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dout[0] !== pat[5-i] || done[0] !== (i == 5)) begin
        failures++;
        $display("FAIL basic_101 cyc=%0d got dout=%b done=%b want dout=%b done=%b",
                 i, dout[0], done[0], pat[5-i], (i == 5));
      end
      @(posedge clk); #1;
    end
    check_idle(0, 1, "basic_after");
  endtask

  task automatic test_back_to_back();
    present(0, 3'b011, "b2b");
    lvl_in[0] = 3'b111;
    run_frame(0, 3'b011, 1'b0, 1'b1, "b2b_first");
    checks++;
    if ({dout[0], busy[0], done[0], lvl_ready[0]} !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_gap got=%b want=0001", {dout[0], busy[0], done[0], lvl_ready[0]});
    end
    @(posedge clk); #1;
    run_frame(0, 3'b111, 1'b0, 1'b0, "b2b_second");
    check_idle(0, 2, "b2b_after");
  endtask

  task automatic test_slow_bits();
    present(1, 3'b100, "slow");
    run_frame(1, 3'b100, 1'b0, 1'b0, "slow_100");
    check_idle(1, 1, "slow_after");
    present(2, 3'b110, "multi_stop");
    run_frame(2, 3'b110, 1'b0, 1'b0, "multi_stop_110");
    check_idle(2, 1, "multi_stop_after");
  endtask

  task automatic test_mid_reset();
    present(0, 3'b110, "midrst");
    lvl_valid[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dout[0] !== 1'b1 || busy[0] !== 1'b1) begin
        failures++;
        $display("FAIL midrst_pre cyc=%0d got dout=%b busy=%b want 1 1", i, dout[0], busy[0]);
      end
      @(posedge clk); #1;
    end
    #2 arst = 1'b0;
    #1;
    checks++;
    if ({dout[0], busy[0], done[0], lvl_ready[0]} !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_async got=%b want=0001", {dout[0], busy[0], done[0], lvl_ready[0]});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done[0] !== 1'b0 || dout[0] !== 1'b0) begin
        failures++;
        $display("FAIL midrst_hold cyc=%0d got done=%b dout=%b want 0 0", i, done[0], dout[0]);
      end
    end
    #2 arst = 1'b1;
    @(posedge clk); #1;
    check_idle(0, 1, "midrst_released");
    present(0, 3'b001, "midrst_new");
    run_frame(0, 3'b001, 1'b0, 1'b0, "midrst_001");
  endtask

  task automatic test_ignore_busy();
    present(0, 3'b010, "ignore");
    run_frame(0, 3'b010, 1'b1, 1'b0, "ignore_010");
    check_idle(0, 3, "ignore_after");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int         k;
      logic [2:0] code;
      k    = int'($urandom_range(NI - 1, 0));
      code = 3'($urandom);
      present(k, code, "rand");
      run_frame(k, code, 1'($urandom), 1'b0, "rand_frame");
      check_idle(k, int'($urandom_range(3, 1)), "rand_idle");
    end
  endtask

  initial begin
    arst      = 1'b0;
    lvl_in    = '0;
    lvl_valid = '0;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_slow_bits();
    test_mid_reset();
    test_ignore_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
